// File: rtl/bin_to_excess3_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_excess3_sequencer
// Description : Multi-cycle binary to excess-3 converter. A shift-and-add-3
//               pass builds the BCD digits, then one shared 4-bit +3 adder
//               encodes one digit per cycle. Valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_excess3_sequencer #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   ex3_out,
    output logic                  busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(BIN_W + 1);
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    // True when DIGITS decimal digits can represent every BIN_W-bit value.
    function automatic bit f_digits_ok(input int bin_w, input int digits);
        logic [255:0] pow10;
        pow10 = 256'd1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 256'd10;
        end
        return pow10 > (256'd1 << bin_w);
    endfunction

    if (!f_digits_ok(BIN_W, DIGITS)) begin : g_param_check
        $error("bin_to_excess3_sequencer: DIGITS too small for BIN_W");
    end

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_ENCODE  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [BIN_W-1:0]       r_shift;
    logic [c_bcd_w-1:0]     r_bcd;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_bcd_w-1:0]     r_ex3;

    logic [c_bcd_w-1:0]     w_bcd_adj;
    logic [c_bcd_w-1:0]     w_bcd_next;
    logic                   w_unused_bcd_msb;
    logic [3:0]             w_sel_bcd;
    logic [3:0]             w_enc_sum;

    // ------------------------------------------------------------------------
    // Add-3 correction: every digit >= 5 is bumped before the shift so that
    // doubling carries correctly into the next decimal digit.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit_adj
        logic [3:0] w_dig;
        assign w_dig                  = r_bcd[4*g +: 4];
        assign w_bcd_adj[4*g +: 4]    = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
    end

    // The adjusted top bit always shifts out as zero for legal parameters.
    assign {w_unused_bcd_msb, w_bcd_next} = {w_bcd_adj, r_shift[BIN_W-1]};

    // Single shared encoder adder; BCD digits are <= 9 so the sum never wraps.
    assign w_sel_bcd = r_bcd[4*r_idx +: 4];
    assign w_enc_sum = w_sel_bcd + 4'd3;

    // ------------------------------------------------------------------------
    // Handshake and status decode from the registered state only.
    // ------------------------------------------------------------------------
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign ex3_out   = r_ex3;

    // Conversion sequencer: accept, double-dabble, per-digit encode, hand off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ex3   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shift <= bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= c_cnt_load;
                        r_state <= ST_CONVERT;
                    end
                end

                ST_CONVERT: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_idx   <= '0;
                        r_state <= ST_ENCODE;
                    end
                end

                ST_ENCODE: begin
                    r_ex3[4*r_idx +: 4] <= w_enc_sum;
                    r_idx               <= r_idx + c_idx_one;
                    if (r_idx == c_idx_last) begin
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_excess3_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_excess3_sequencer
// Description : Directed self-checking bench for bin_to_excess3_sequencer
//               with default parameters (8-bit input, 3 digits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_excess3_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bin_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] ex3_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bin_to_excess3_sequencer #(
        .BIN_W  (8),
        .DIGITS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ex3_out   (ex3_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench itself stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of v, each plus three.
    function automatic logic [11:0] ex3_ref(input int v);
        logic [3:0] d0, d1, d2;
        d0 = 4'((v % 10) + 3);
        d1 = 4'(((v / 10) % 10) + 3);
        d2 = 4'(((v / 100) % 10) + 3);
        return {d2, d1, d0};
    endfunction

    // Called at a negedge with the DUT in IDLE.
    task automatic run_word(input logic [7:0] value, input logic [11:0] exp,
                            input bit noise, input int stall, input bit ready_early,
                            input string tag);
        int  k;
        bit  seen;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        bin_in    = value;
        out_ready = ready_early;
        @(posedge clk);
        @(negedge clk);
        in_valid = noise;
        if (noise) bin_in = 8'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (out_valid) begin
                seen = 1'b1;
            end else if (noise) begin
                in_valid = 1'b1;
                bin_in   = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(k), 32'd11);
        check({tag, "_ex3"}, 32'(ex3_out), 32'(exp));
        if (!ready_early) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_ex3"}, 32'(ex3_out), 32'(exp));
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_ex3"}, 32'(ex3_out), 32'(exp));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin_in    = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ex3", 32'(ex3_out), 32'h000);

        // Directed vectors
        run_word(8'd0,   12'h333, 1'b0, 0, 1'b0, "zero");
        run_word(8'd255, 12'h588, 1'b0, 5, 1'b0, "max_stall");
        run_word(8'd128, 12'h45B, 1'b1, 1, 1'b0, "noise_128");
        run_word(8'd99,  12'h3CC, 1'b0, 0, 1'b1, "early_ready_99");

        // Abort mid-conversion with an asynchronous reset between edges
        in_valid = 1'b1;
        bin_in   = 8'd200;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_ex3", 32'(ex3_out), 32'h000);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_in_ready", 32'(in_ready), 32'd1);
        check("areset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_word(8'd37, 12'h36A, 1'b0, 0, 1'b0, "after_reset_37");

        // Full input range with random stalls and input noise
        for (int v = 0; v < 256; v++) begin
            run_word(8'(v), ex3_ref(v), (v % 3) == 0, int'($urandom_range(0, 3)),
                     (v % 7) == 0, "exhaustive");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
